// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals shared by mem_port_arbiter and its users.
// Carries the wait counters only when MEM_ARB_STATS_EN is defined.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   cpu_wait_cnt;
  logic [15:0]   dbg_wait_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy, owner, cpu_wait_cnt, dbg_wait_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy, owner, cpu_wait_cnt, dbg_wait_cnt
  );
`else
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
`endif
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and a debug/loader port.
// Defining MEM_ARB_STATS_EN adds saturating per-requester wait-cycle counters.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t        state_r;
  logic [3:0]    lat_cnt_r;
  logic          owner_r;
  logic          txn_we_r;
  logic          busy_r;
  logic          cpu_ack_r;
  logic          dbg_ack_r;
  logic [DW-1:0] cpu_rdata_r;
  logic [DW-1:0] dbg_rdata_r;
  logic [AW-1:0] mem_addr_r;
  logic          mem_we_r;
  logic [DW-1:0] mem_wdata_r;

  logic          grant_valid_s;
  logic          grant_dbg_s;

  // Winner selection: a tie goes to whichever requester was not granted last
  always_comb begin
    grant_valid_s = 1'b0;
    grant_dbg_s   = 1'b0;
    if (bus.cpu_req && bus.dbg_req) begin
      grant_valid_s = 1'b1;
      grant_dbg_s   = ~owner_r;
    end else if (bus.cpu_req) begin
      grant_valid_s = 1'b1;
      grant_dbg_s   = 1'b0;
    end else if (bus.dbg_req) begin
      grant_valid_s = 1'b1;
      grant_dbg_s   = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_dbg_s   = 1'b0;
    end
  end

  // Transaction FSM with all memory-side and requester-side outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      lat_cnt_r   <= 4'd0;
      owner_r     <= 1'b1;
      txn_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      cpu_ack_r   <= 1'b0;
      dbg_ack_r   <= 1'b0;
      cpu_rdata_r <= '0;
      dbg_rdata_r <= '0;
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cpu_ack_r <= 1'b0;
          dbg_ack_r <= 1'b0;
          if (grant_valid_s) begin
            owner_r     <= grant_dbg_s;
            mem_addr_r  <= grant_dbg_s ? bus.dbg_addr  : bus.cpu_addr;
            mem_wdata_r <= grant_dbg_s ? bus.dbg_wdata : bus.cpu_wdata;
            mem_we_r    <= grant_dbg_s ? bus.dbg_we    : bus.cpu_we;
            txn_we_r    <= grant_dbg_s ? bus.dbg_we    : bus.cpu_we;
            lat_cnt_r   <= LAT_INIT;
            busy_r      <= 1'b1;
            state_r     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The write strobe lives only in the first access cycle
          mem_we_r  <= 1'b0;
          lat_cnt_r <= lat_cnt_r - 4'd1;
          if (lat_cnt_r == 4'd1) begin
            if (!txn_we_r) begin
              if (owner_r) begin
                dbg_rdata_r <= bus.mem_rdata;
              end else begin
                cpu_rdata_r <= bus.mem_rdata;
              end
            end
            cpu_ack_r <= ~owner_r;
            dbg_ack_r <= owner_r;
            state_r   <= ST_RESP;
          end
        end
        ST_RESP: begin
          cpu_ack_r <= 1'b0;
          dbg_ack_r <= 1'b0;
          mem_we_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          cpu_ack_r <= 1'b0;
          dbg_ack_r <= 1'b0;
          mem_we_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dbg_ack   = dbg_ack_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.dbg_rdata = dbg_rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.owner     = owner_r;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_wait_cnt_r;
  logic [15:0] dbg_wait_cnt_r;
  logic        cpu_served_s;
  logic        dbg_served_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A requester is served while being granted, in progress, or in its response cycle
  always_comb begin
    cpu_served_s = 1'b0;
    dbg_served_s = 1'b0;
    if (state_r == ST_IDLE) begin
      cpu_served_s = grant_valid_s & ~grant_dbg_s;
      dbg_served_s = grant_valid_s & grant_dbg_s;
    end else begin
      cpu_served_s = ~owner_r;
      dbg_served_s = owner_r;
    end
  end

  // Saturating wait counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_wait_cnt_r <= 16'd0;
      dbg_wait_cnt_r <= 16'd0;
    end else begin
      if (bus.cpu_req && !cpu_served_s) begin
        cpu_wait_cnt_r <= sat_inc(cpu_wait_cnt_r);
      end
      if (bus.dbg_req && !dbg_served_s) begin
        dbg_wait_cnt_r <= sat_inc(dbg_wait_cnt_r);
      end
    end
  end

  assign bus.cpu_wait_cnt = cpu_wait_cnt_r;
  assign bus.dbg_wait_cnt = dbg_wait_cnt_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance for most tests, MEM_LAT=3 for latency.
// Checks the wait counters too when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          port;   // 0 = CPU, 1 = debug
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic reset3;
  logic preload;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   we_cycles = 0;
  exp_t sb_q[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset),  .bus(bus1.slave));
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset3), .bus(bus3.slave));

  // Memory model: combinational read of the held address, write on the clock edge
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'hA5A50001;
      mem[8'h40] <= 32'h0BADF00D;
    end else if (bus1.mem_we) begin
      mem[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
  end
  always_comb bus1.mem_rdata = mem[bus1.mem_addr[7:0]];
  always_comb bus3.mem_rdata = mem[bus3.mem_addr[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the next expected response
  always @(negedge clk) begin
    exp_t e;
    if (bus1.mem_we === 1'b1) we_cycles++;
    if (bus1.cpu_ack === 1'b1 || bus1.dbg_ack === 1'b1) begin
      check("single_ack", {31'd0, bus1.cpu_ack & bus1.dbg_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus1.dbg_ack, bus1.cpu_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", {31'd0, bus1.dbg_ack}, {31'd0, e.port});
        check("ack_cycle", cyc, e.cyc);
        check("ack_rdata", e.port ? bus1.dbg_rdata : bus1.cpu_rdata, e.rdata);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus1.dbg_we = we; bus1.dbg_addr = addr; bus1.dbg_wdata = wdata; bus1.dbg_req = 1'b1;
    end else begin
      bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata; bus1.cpu_req = 1'b1;
    end
  endtask

  task automatic expect_ack(input bit port, input logic [31:0] rdata, input int at);
    exp_t e;
    e.port = port; e.rdata = rdata; e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Bounded wait for n acks on a port, then drop the request in the following cycle
  task automatic wait_ack(input bit port, input int n);
    int seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk);
      if ((port ? bus1.dbg_ack : bus1.cpu_ack) === 1'b1) seen++;
    end
    check(port ? "dbg_ack_timeout" : "cpu_ack_timeout", seen, n);
    @(posedge clk);
    #1;
    if (port) bus1.dbg_req = 1'b0;
    else bus1.cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; reset3 = 1'b1; preload = 1'b1;
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h0; bus1.cpu_wdata = 32'h0;
    bus1.dbg_req = 1'b0; bus1.dbg_we = 1'b0; bus1.dbg_addr = 32'h0; bus1.dbg_wdata = 32'h0;
    bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h0; bus3.cpu_wdata = 32'h0;
    bus3.dbg_req = 1'b0; bus3.dbg_we = 1'b0; bus3.dbg_addr = 32'h0; bus3.dbg_wdata = 32'h0;
    repeat (3) next_cycle();

    check("rst_busy",      {31'd0, bus1.busy},    32'd0);
    check("rst_owner",     {31'd0, bus1.owner},   32'd1);
    check("rst_mem_we",    {31'd0, bus1.mem_we},  32'd0);
    check("rst_mem_addr",  bus1.mem_addr,         32'd0);
    check("rst_cpu_rdata", bus1.cpu_rdata,        32'd0);
    check("rst_dbg_rdata", bus1.dbg_rdata,        32'd0);
    check("rst_acks",      {30'd0, bus1.cpu_ack, bus1.dbg_ack}, 32'd0);
    reset = 1'b0; reset3 = 1'b0; preload = 1'b0;

    // CPU read alone
    n = cyc;
    start(1'b0, 1'b0, 32'h10, 32'h0);
    expect_ack(1'b0, 32'hDEADBEEF, n + 2);
    @(negedge clk);
    @(negedge clk);
    check("t1_mem_addr", bus1.mem_addr, 32'h10);
    check("t1_busy", {31'd0, bus1.busy}, 32'd1);
    wait_ack(1'b0, 1);

    // Debug write, then CPU read-back
    we_cycles = 0;
    n = cyc;
    start(1'b1, 1'b1, 32'h20, 32'h12345678);
    expect_ack(1'b1, 32'h0, n + 2);
    wait_ack(1'b1, 1);
    check("t2_we_cycles", we_cycles, 32'd1);
    n = cyc;
    start(1'b0, 1'b0, 32'h20, 32'h0);
    expect_ack(1'b0, 32'h12345678, n + 2);
    wait_ack(1'b0, 1);

    // Tie after reset, both held: CPU, DBG, CPU, DBG
    do_reset();
    n = cyc;
    expect_ack(1'b0, 32'hA5A50001, n + 2);
    expect_ack(1'b1, 32'h0BADF00D, n + 5);
    expect_ack(1'b0, 32'hA5A50001, n + 8);
    expect_ack(1'b1, 32'h0BADF00D, n + 11);
    start(1'b0, 1'b0, 32'h30, 32'h0);
    start(1'b1, 1'b0, 32'h40, 32'h0);
    fork
      wait_ack(1'b0, 2);
      wait_ack(1'b1, 2);
`ifdef MEM_ARB_STATS_EN
      begin
        repeat (4) @(negedge clk);
        check("t6_dbg_wait_cnt", {16'd0, bus1.dbg_wait_cnt}, 32'd3);
        check("t6_cpu_wait_cnt", {16'd0, bus1.cpu_wait_cnt}, 32'd0);
      end
`endif
    join

    // Reset during the access cycle of a CPU write
    start(1'b0, 1'b1, 32'h50, 32'hCAFE0001);
    next_cycle();
    reset = 1'b1;
    bus1.cpu_req = 1'b0;
    @(negedge clk);
    check("t5_we_issued", {31'd0, bus1.mem_we}, 32'd1);
    next_cycle();
    check("t5_busy",    {31'd0, bus1.busy},    32'd0);
    check("t5_mem_we",  {31'd0, bus1.mem_we},  32'd0);
    check("t5_owner",   {31'd0, bus1.owner},   32'd1);
    check("t5_cpu_ack", {31'd0, bus1.cpu_ack}, 32'd0);
    next_cycle();
    reset = 1'b0;
    n = cyc;
    start(1'b0, 1'b0, 32'h50, 32'h0);
    expect_ack(1'b0, 32'hCAFE0001, n + 2);
    wait_ack(1'b0, 1);

    // MEM_LAT=3 instance: busy over cycles 1..4, ack at cycle 4
    bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h10; bus3.cpu_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t4_busy",    {31'd0, bus3.busy},    {31'd0, (k >= 1 && k <= 4)});
      check("t4_cpu_ack", {31'd0, bus3.cpu_ack}, {31'd0, (k == 4)});
      check("t4_dbg_ack", {31'd0, bus3.dbg_ack}, 32'd0);
      if (k == 4) begin
        check("t4_rdata", bus3.cpu_rdata, 32'hDEADBEEF);
        bus3.cpu_req = 1'b0;
      end
    end

    next_cycle();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
